// File: rtl/universal_shift_reg.sv
// Universal shift register with a valid/ready command port.
// One accepted command runs a burst of up to 2^LEN_W-1 steps on its own
// (shift left/right, rotate left/right, arithmetic shift right), or performs
// a single-cycle load/clear/hold, and then pulses done for one cycle.
module universal_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_mode,
    input  logic [LEN_W-1:0] op_len,
    input  logic [WIDTH-1:0] par_in,
    input  logic [STEP-1:0]  ser_in,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic [STEP-1:0]  ser_out_msb,
    output logic [STEP-1:0]  ser_out_lsb,
    output logic             busy,
    output logic [LEN_W-1:0] remaining,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        MD_HOLD  = 3'd0,
        MD_SHL   = 3'd1,
        MD_SHR   = 3'd2,
        MD_ROTL  = 3'd3,
        MD_ROTR  = 3'd4,
        MD_ASR   = 3'd5,
        MD_LOAD  = 3'd6,
        MD_CLEAR = 3'd7
    } mode_t;

    state_t             r_state;
    state_t             w_state_nxt;
    mode_t              r_mode;
    mode_t              w_mode_nxt;
    mode_t              w_op_mode;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;

    // One step of a shifting mode; non-shifting modes return the data unchanged.
    function automatic logic [WIDTH-1:0] f_step(
        input mode_t            m,
        input logic [WIDTH-1:0] d,
        input logic [STEP-1:0]  s
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            MD_SHL:  r = {d[WIDTH-STEP-1:0], s};
            MD_SHR:  r = {s, d[WIDTH-1:STEP]};
            MD_ROTL: r = {d[WIDTH-STEP-1:0], d[WIDTH-1:WIDTH-STEP]};
            MD_ROTR: r = {d[STEP-1:0], d[WIDTH-1:STEP]};
            MD_ASR:  r = {{STEP{d[WIDTH-1]}}, d[WIDTH-1:STEP]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state, next-data and completion logic for both states.
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_data_nxt      = r_data;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        w_op_mode       = mode_t'(op_mode);
        w_accept        = op_valid && (r_state == ST_IDLE) && !abort;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op_mode)
                        MD_LOAD: begin
                            w_data_nxt = par_in;
                            w_done_nxt = 1'b1;
                        end
                        MD_CLEAR: begin
                            w_data_nxt = '0;
                            w_done_nxt = 1'b1;
                        end
                        MD_HOLD: begin
                            w_done_nxt = 1'b1;
                        end
                        default: begin
                            // The first step of a burst happens on the accept edge,
                            // so only bursts of two or more steps enter RUN.
                            if (op_len == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_data_nxt = f_step(w_op_mode, r_data, ser_in);
                                if (op_len == LEN_W'(1)) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt     = ST_RUN;
                                    w_mode_nxt      = w_op_mode;
                                    w_remaining_nxt = op_len - LEN_W'(1);
                                end
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = '0;
                end else begin
                    w_data_nxt      = f_step(r_mode, r_data, ser_in);
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and burst bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MD_HOLD;
            r_data      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_data      <= w_data_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign op_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_RUN);
    assign remaining   = r_remaining;
    assign done        = r_done;
    assign data_out    = r_data;
    assign ser_out_msb = r_data[WIDTH-1:WIDTH-STEP];
    assign ser_out_lsb = r_data[STEP-1:0];

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register with a valid/ready command port and burst sequencing. It supports multi-bit steps, shifts in both directions, rotates, arithmetic right shift, parallel load and clear. A single accepted command performs up to 2^LEN_W-1 steps autonomously and then emits a one-cycle done pulse. It is the general serialiser/deserialiser and bit-manipulation element for the datapath blocks in this chapter.

## Interface
- WIDTH, 8: register width in bits; must be a multiple of STEP.
- STEP, 1: bits moved per step; 1 ≤ STEP < WIDTH.
- LEN_W, 4: width of the burst-length field.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  command present.
- op_ready  out  1  high in IDLE; command accepted on an edge where op_valid && op_ready && !abort.
- op_mode  in  3  0 HOLD, 1 SHL, 2 SHR, 3 ROTL, 4 ROTR, 5 ASR, 6 LOAD, 7 CLEAR.
- op_len  in  LEN_W  number of steps for modes 1–5; ignored otherwise.
- par_in  in  WIDTH  parallel data for LOAD.
- ser_in  in  STEP  serial fill bits, sampled on every SHL/SHR step edge.
- abort  in  1  synchronous burst cancel.
- data_out  out  WIDTH  register contents.
- ser_out_msb  out  STEP  data_out[WIDTH-1:WIDTH-STEP], combinational from the register.
- ser_out_lsb  out  STEP  data_out[STEP-1:0], combinational from the register.
- busy  out  1  high in RUN.
- remaining  out  LEN_W  steps still to perform after the current edge; 0 in IDLE.
- done  out  1  one-cycle pulse on command completion.

## Operation
- States: IDLE and RUN. Registered mode and count are latched at acceptance.
- Step functions, with d = data_out and S = STEP:
  - SHL: {d[W-S-1:0], ser_in}
  - SHR: {ser_in, d[W-1:S]}
  - ROTL: {d[W-S-1:0], d[W-1:W-S]}
  - ROTR: {d[S-1:0], d[W-1:S]}
  - ASR: {{S{d[W-1]}}, d[W-1:S]}
- On acceptance, by command:
  - LOAD: d <= par_in.
  - CLEAR: d <= 0.
  - HOLD, or modes 1–5 with op_len==0: d unchanged.
  - All of the above stay in IDLE and set done <= 1.
  - Modes 1–5 with op_len==1: one step on the accept edge; stay in IDLE; done <= 1.
  - Modes 1–5 with op_len==N≥2: first step on the accept edge; remaining <= N-1; go to RUN.
- In RUN, on each edge without abort: one step; remaining decrements. When remaining==1, the step is performed, state goes to IDLE, remaining becomes 0, and done <= 1.
- In RUN with abort=1: no step; go to IDLE; remaining <= 0; done stays 0.
- op_valid while in RUN is ignored and has no side effects.
- Abort in IDLE blocks acceptance that cycle.
- done is cleared on every edge where it is not being set.

## Timing
- Reset values: data_out=0, state IDLE, busy=0, remaining=0, done=0, op_ready=1. ser_out_* follow data_out and are therefore 0.
- Reset asserted mid-burst clears all state immediately; no done pulse is produced.
- Burst of N≥1 steps accepted at edge 0: steps occur at edges 0..N-1.
  - busy is high for N-1 cycles.
  - done is high in the cycle after edge N-1, the same cycle op_ready returns high.
- A new command may be accepted in the done cycle; back-to-back throughput is N cycles per N-step burst.
- Single-cycle commands (LOAD, CLEAR, HOLD, len≤1): done is high the cycle after acceptance. Such commands may be issued every cycle, and done then stays high continuously.
- ser_out_* reflect the register after the most recent edge; there is no extra latency.

## Test plan
- Reset: assert rst_n=0 mid-burst (SHL, len 10, after 3 steps) -> data_out=0, busy=0, remaining=0, done=0 immediately; op_ready=1.
- WIDTH=8, STEP=1: LOAD 0xA5, then SHL len 3 with ser_in=1 -> data_out=0x2F; busy high 2 cycles; done single pulse one cycle after the 3rd step edge.
- ROTR len 8 on 0xA5 -> 0xA5, with done after 8 cycles. ASR len 3 on 0x80 -> 0xF0. ROTL len 1 on 0x81 -> 0x03, with no RUN cycle.
- STEP=2: LOAD 0x1B, then SHR len 2 with ser_in=2'b10 -> data_out=0xA1; ser_out_lsb=2'b01, ser_out_msb=2'b10.
- Abort: LOAD 0x01, SHL len 5 with ser_in=0, abort high in the first RUN cycle -> data_out=0x02; done never pulses; op_ready=1 the next cycle; a following LOAD is accepted.
- Handshake edges:
  - op_valid held with ROTL during RUN -> ignored.
  - SHL len 0 -> data unchanged, done pulses.
  - op_valid together with abort in IDLE -> not accepted, no done.
